// File: rtl/chip8_keypad.sv
// chip8_keypad
//   Keypad responder for the CHIP-8 core. Synchronises and debounces the 16
//   hex keys, answers per-key state queries (EX9E / EXA1) and runs the FX0A
//   wait-for-key handshake (fresh press, then release of that key).
//
// Ports
//   clk_in         system clock
//   rst_in         synchronous active-low reset
//   keys_in[15:0]  raw key levels, bit k = hex key k, 1 = pressed (async)
//   req_key_in[4:0] [3:0] key index for state query, [4] wait-for-key request
//   key_state_out  debounced state of key req_key_in[3:0], registered
//   any_key_out    index of the key that completed the last wait
//   valid_key_out  one-cycle pulse: wait complete, any_key_out valid
//   keys_out[15:0] debounced key vector
module chip8_keypad #(
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [15:0] keys_in,
    input  logic [4:0]  req_key_in,
    output logic        key_state_out,
    output logic [3:0]  any_key_out,
    output logic        valid_key_out,
    output logic [15:0] keys_out
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PRESS,
        WAIT_RELEASE,
        DONE,
        ACK
    } state_t;

    state_t           state;
    logic [15:0]      sync1_q;
    logic [15:0]      sync2_q;
    logic [15:0]      sample_q;
    logic [15:0]      db_q;
    logic [15:0]      new_press;
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    logic [3:0]       sel;
    logic [3:0]       first_idx;
    logic             found;

    assign tick      = (tick_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign new_press = keys_out & ~db_q;

    // Two-flop synchroniser; everything downstream sees only sync2_q.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= keys_in;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // A level is accepted only when two consecutive tick samples agree.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            sample_q <= '0;
            keys_out <= '0;
        end else if (tick) begin
            sample_q <= sync2_q;
            for (int unsigned i = 0; i < 16; i++) begin
                if (sync2_q[i] == sample_q[i]) begin
                    keys_out[i] <= sync2_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            db_q          <= '0;
            key_state_out <= 1'b0;
        end else begin
            db_q          <= keys_out;
            key_state_out <= keys_out[req_key_in[3:0]];
        end
    end

    // Lowest-index new press wins when several arrive together.
    always_comb begin
        first_idx = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (new_press[i] && !found) begin
                first_idx = 4'(i);
                found     = 1'b1;
            end
        end
    end

    // valid_key_out is raised on entry to DONE and dropped on leaving it,
    // so it is high exactly while the FSM sits in DONE.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state         <= IDLE;
            sel           <= '0;
            any_key_out   <= '0;
            valid_key_out <= 1'b0;
        end else begin
            valid_key_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_key_in[4]) begin
                        state <= WAIT_PRESS;
                    end
                end
                WAIT_PRESS: begin
                    if (!req_key_in[4]) begin
                        state <= IDLE;
                    end else if (found) begin
                        sel   <= first_idx;
                        state <= WAIT_RELEASE;
                    end
                end
                WAIT_RELEASE: begin
                    if (!req_key_in[4]) begin
                        state <= IDLE;
                    end else if (!keys_out[sel]) begin
                        state         <= DONE;
                        valid_key_out <= 1'b1;
                        any_key_out   <= sel;
                    end
                end
                DONE: begin
                    state <= ACK;
                end
                ACK: begin
                    if (!req_key_in[4]) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chip8_keypad.sv
// tb_chip8_keypad
//   Directed bench for chip8_keypad with DEBOUNCE_CYCLES = 4. Inputs change
//   and outputs are sampled on the falling clock edge.
module tb_chip8_keypad;

    logic        clk_in;
    logic        rst_in;
    logic [15:0] keys_in;
    logic [4:0]  req_key_in;
    logic        key_state_out;
    logic [3:0]  any_key_out;
    logic        valid_key_out;
    logic [15:0] keys_out;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    int base;
    int cyc;
    logic [3:0] pulse_key = '0;
    logic       glitch_seen;

    chip8_keypad #(.DEBOUNCE_CYCLES(4)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .keys_in       (keys_in),
        .req_key_in    (req_key_in),
        .key_state_out (key_state_out),
        .any_key_out   (any_key_out),
        .valid_key_out (valid_key_out),
        .keys_out      (keys_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Pulse monitor: one count per clk cycle that valid_key_out is high.
    always @(negedge clk_in) begin
        if (valid_key_out === 1'b1) begin
            pulses    = pulses + 1;
            pulse_key = any_key_out;
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // Bounded wait for keys_out to settle to a value.
    task automatic wait_keys(input string tag, input logic [15:0] exp, input int bound);
        int n;
        n = 0;
        while (keys_out !== exp && n < bound) begin
            @(negedge clk_in);
            n++;
        end
        check(tag, keys_out, exp);
    endtask

    // Bounded wait for the pulse count to reach a target.
    task automatic wait_pulse(input string tag, input int target, input int bound);
        int n;
        n = 0;
        while (pulses < target && n < bound) begin
            @(negedge clk_in);
            n++;
        end
        check(tag, 16'(pulses), 16'(target));
    endtask

    initial begin
        rst_in     = 1'b0;
        keys_in    = 16'hFFFF;
        req_key_in = 5'h00;

        // Reset with all keys pressed
        cycles(3);
        check("rst_keys_out", keys_out, 16'h0000);
        check("rst_valid", 16'(valid_key_out), 16'h0000);
        check("rst_any_key", 16'(any_key_out), 16'h0000);
        check("rst_key_state", 16'(key_state_out), 16'h0000);
        rst_in = 1'b1;
        wait_keys("post_rst_all_keys", 16'hFFFF, 10);
        keys_in = 16'h0000;
        wait_keys("all_released", 16'h0000, 12);

        // Glitch on key 5: two cycles high
        keys_in = 16'h0020;
        cycles(2);
        keys_in = 16'h0000;
        glitch_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            if (keys_out[5] !== 1'b0) glitch_seen = 1'b1;
        end
        check("glitch_filtered", 16'(glitch_seen), 16'h0000);

        // Key 5 held
        keys_in = 16'h0020;
        wait_keys("key5_held", 16'h0020, 10);
        req_key_in = 5'h05;
        cycles(1);
        check("query_key5", 16'(key_state_out), 16'h0001);
        req_key_in = 5'h06;
        cycles(1);
        check("query_key6", 16'(key_state_out), 16'h0000);
        req_key_in = 5'h15;
        cycles(1);
        check("query_key5_req4_high", 16'(key_state_out), 16'h0001);
        req_key_in = 5'h00;
        keys_in = 16'h0000;
        wait_keys("key5_released", 16'h0000, 12);
        cycles(3);

        // Normal wait: key A press then release
        base = pulses;
        req_key_in = 5'h10;
        keys_in = 16'h0400;
        cycles(20);
        check("wait_no_pulse_on_press", 16'(pulses - base), 16'h0000);
        keys_in = 16'h0000;
        wait_pulse("wait_pulse_after_release", base + 1, 30);
        check("wait_any_key_A", 16'(pulse_key), 16'h000A);
        check("wait_any_key_hold", 16'(any_key_out), 16'h000A);
        cycles(50);
        check("wait_single_pulse", 16'(pulses - base), 16'h0001);
        check("valid_low_in_ack", 16'(valid_key_out), 16'h0000);
        req_key_in = 5'h00;
        cycles(3);

        // Pre-held key 3
        keys_in = 16'h0008;
        wait_keys("key3_preheld", 16'h0008, 12);
        cycles(2);
        base = pulses;
        req_key_in = 5'h10;
        cycles(20);
        check("preheld_no_pulse_held", 16'(pulses - base), 16'h0000);
        keys_in = 16'h0000;
        wait_keys("key3_released", 16'h0000, 12);
        cycles(10);
        check("preheld_no_pulse_release", 16'(pulses - base), 16'h0000);
        keys_in = 16'h0008;
        wait_keys("key3_repressed", 16'h0008, 12);
        cycles(5);
        check("preheld_no_pulse_repress", 16'(pulses - base), 16'h0000);
        keys_in = 16'h0000;
        wait_pulse("preheld_pulse", base + 1, 30);
        check("preheld_any_key_3", 16'(pulse_key), 16'h0003);
        req_key_in = 5'h00;
        cycles(3);

        // Simultaneous press of keys 2 and 9
        base = pulses;
        req_key_in = 5'h10;
        cycles(2);
        keys_in = 16'h0204;
        wait_keys("sim_pressed", 16'h0204, 12);
        cycles(3);
        keys_in = 16'h0004;
        wait_keys("sim_key9_released", 16'h0004, 12);
        cycles(10);
        check("sim_no_pulse_key9", 16'(pulses - base), 16'h0000);
        keys_in = 16'h0000;
        wait_pulse("sim_pulse_key2", base + 1, 30);
        check("sim_any_key_2", 16'(pulse_key), 16'h0002);
        req_key_in = 5'h00;
        cycles(3);

        // Abort by dropping the request during WAIT_RELEASE
        base = pulses;
        req_key_in = 5'h10;
        cycles(2);
        keys_in = 16'h0080;
        wait_keys("abort_key7_pressed", 16'h0080, 12);
        cycles(3);
        req_key_in = 5'h00;
        cycles(1);
        keys_in = 16'h0000;
        wait_keys("abort_key7_released", 16'h0000, 12);
        cycles(10);
        check("abort_no_pulse", 16'(pulses - base), 16'h0000);
        check("abort_any_key_holds", 16'(any_key_out), 16'h0002);
        // Re-raised request must start a fresh wait, not complete the old one
        req_key_in = 5'h10;
        cycles(20);
        check("abort_idle_no_pulse", 16'(pulses - base), 16'h0000);

        // Reset while in WAIT_PRESS
        rst_in = 1'b0;
        cycles(2);
        check("midrst_any_key", 16'(any_key_out), 16'h0000);
        check("midrst_valid", 16'(valid_key_out), 16'h0000);
        rst_in = 1'b1;
        cycles(30);
        check("midrst_no_pulse", 16'(pulses - base), 16'h0000);
        req_key_in = 5'h00;
        cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        cyc = 0;
        while (cyc < 20000) begin
            @(posedge clk_in);
            cyc++;
        end
        $display("FAIL timeout observed=%0d cycles expected=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/chip8_keypad.md
Name: chip8_keypad

Overview:
- Keypad responder for the CHIP-8 core. It synchronises and debounces the 16 hex keys.
- Answers the processor's per-key state queries, used by the EX9E and EXA1 skip instructions.
- Runs the FX0A wait-for-key handshake: waits for a fresh press followed by its release, then returns the key index with a one-cycle valid pulse.
- Sits between the board button/PMOD inputs and the processor's key request/response ports.

Parameters:
- DEBOUNCE_CYCLES, 100000, clk_in cycles between debounce samples (1 ms at 100 MHz); must be >= 2.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset; synchronous, active-low
- keys_in  input  16  raw key levels, bit k = hex key k, 1 = pressed; asynchronous to clk_in
- req_key_in  input  5  [3:0] key index for state query; [4] level-held wait-for-key request
- key_state_out  output  1  debounced state of key req_key_in[3:0], registered
- any_key_out  output  4  index of the key that completed the last wait
- valid_key_out  output  1  one-cycle pulse: wait complete, any_key_out valid
- keys_out  output  16  debounced key vector

Behaviour:
- Reset (rst_in low at a clk_in edge): all outputs 0, FSM to IDLE, tick counter 0, sync/sample/edge registers 0.
- Synchronisation: keys_in passes through a 2-flop synchroniser per bit; nothing downstream uses keys_in directly.
- Tick counter: counts 0..DEBOUNCE_CYCLES-1, wraps, and asserts tick for one cycle at wrap.
- Debounce, on tick, per bit:
  - sample_q <= sync.
  - If sync == sample_q (old value), keys_out <= sync; otherwise keys_out holds.
  - A raw change held stable appears on keys_out at the second tick after it reaches the synchroniser output, so worst-case latency is 2*DEBOUNCE_CYCLES+2 cycles.
  - A glitch shorter than one tick period never reaches keys_out.
- State query: key_state_out <= keys_out[req_key_in[3:0]] every cycle.
  - One-cycle latency from the index change.
  - Independent of req_key_in[4] and of the FSM.
- Edge detect: db_q <= keys_out every cycle; new_press = keys_out & ~db_q.
- FSM states:
  - IDLE: if req_key_in[4] = 1, go to WAIT_PRESS.
  - WAIT_PRESS: if req_key_in[4] = 0, go to IDLE. Else if new_press != 0, latch sel = lowest set index of new_press and go to WAIT_RELEASE.
  - WAIT_RELEASE: if req_key_in[4] = 0, go to IDLE with no pulse. Else if keys_out[sel] = 0, go to DONE. Other keys pressed or released meanwhile are ignored.
  - DONE: valid_key_out = 1 and any_key_out = sel for exactly this cycle, then go to ACK.
  - ACK: stay while req_key_in[4] = 1; go to IDLE when it is 0. No second pulse is issued for the same request.
- Keys already held when the request rises do not qualify; they must be released and pressed again. This follows from edge-only detection.
- Simultaneous new presses in the same cycle: lowest index wins.
- any_key_out holds its value between waits. valid_key_out is 0 in every state except DONE.
- Reset mid-wait: FSM returns to IDLE immediately with no pulse.

Test Plan (DEBOUNCE_CYCLES = 4):
- Reset: hold rst_in = 0 for 3 cycles while keys_in = 16'hFFFF -> keys_out = 0, valid_key_out = 0, any_key_out = 0. After release, keys_out reaches 16'hFFFF within 10 cycles.
- Debounce:
  - Key 5 high for 2 cycles, then low -> keys_out[5] never asserts.
  - Key 5 held high -> keys_out[5] = 1 within 10 cycles.
  - req_key_in = 5'h05 -> key_state_out = 1 one cycle later.
  - req_key_in = 5'h06 -> key_state_out = 0.
- Wait, normal: req_key_in = 5'h10, press key A for 20 cycles, then release -> exactly one valid_key_out pulse with any_key_out = 4'hA. The pulse follows the release, not the press. Holding req_key_in[4] high for 50 more cycles produces no further pulse.
- Wait, pre-held key: key 3 held before req_key_in[4] rises; release key 3, press key 3 again, release -> pulse with any_key_out = 3 only after the second release.
- Simultaneous press: keys 2 and 9 pressed in the same cycle during WAIT_PRESS. Release key 9 -> no pulse. Release key 2 -> pulse with any_key_out = 2.
- Abort:
  - req_key_in[4] drops during WAIT_RELEASE -> no pulse; FSM returns to IDLE.
  - rst_in = 0 during WAIT_PRESS -> no pulse; any_key_out = 0.
